// File: rtl/iloveyou_flow_gen.sv
// rtl/iloveyou_flow_gen.sv - two-lane "ILoveYou" character source; optional decoy gaps via ILY_DECOY_EN
module iloveyou_flow_gen #(
  parameter int          HOLD    = 1,
  parameter int          GAP     = 2,
  parameter int          MSG_GAP = 4,
  parameter logic [7:0]  FILL    = 8'h5F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        repeat_en,
  output logic [7:0]  cap_flow,
  output logic [7:0]  low_flow,
  output logic [3:0]  char_idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] msg_cnt
);

  localparam int MAXP = (HOLD > GAP) ? ((HOLD > MSG_GAP) ? HOLD : MSG_GAP)
                                     : ((GAP > MSG_GAP) ? GAP : MSG_GAP);
  localparam int CW   = $clog2(MAXP + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
  localparam logic [CW-1:0] TAIL_LAST = CW'(MSG_GAP - 1);
  // done is loaded one edge early so it is visible during the last TAIL cycle
  localparam logic [CW-1:0] TAIL_DONE = CW'(MSG_GAP - 2);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP, S_TAIL} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_cap;
  logic [7:0]    r_low;
  logic          r_busy;
  logic          r_done;
  logic [15:0]   r_msg_cnt;

  function automatic logic [7:0] msg_char(input logic [2:0] i);
    case (i)
      3'd0:    msg_char = 8'h49; // I
      3'd1:    msg_char = 8'h4C; // L
      3'd2:    msg_char = 8'h6F; // o
      3'd3:    msg_char = 8'h76; // v
      3'd4:    msg_char = 8'h65; // e
      3'd5:    msg_char = 8'h59; // Y
      3'd6:    msg_char = 8'h6F; // o
      default: msg_char = 8'h75; // u
    endcase
  endfunction

  function automatic logic msg_is_cap(input logic [2:0] i);
    msg_is_cap = (i == 3'd0) || (i == 3'd1) || (i == 3'd5);
  endfunction

  logic [7:0] w_dec_cap;
  logic [7:0] w_dec_low;

`ifdef ILY_DECOY_EN
  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_next;
  logic [4:0] w_rnd;

  // x^8+x^6+x^5+x^4+1 Fibonacci form; outputs use the value the LFSR holds next cycle
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_rnd       = w_lfsr_next[4:0];
  assign w_dec_cap   = (w_rnd < 5'd26) ? (8'h41 + {3'b000, w_rnd}) : FILL;
  assign w_dec_low   = (w_rnd < 5'd26) ? (8'h61 + {3'b000, w_rnd}) : FILL;

  // free-running decoy generator
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= 8'hA5;
    else     r_lfsr <= w_lfsr_next;
  end
`else
  assign w_dec_cap = FILL;
  assign w_dec_low = FILL;
`endif

  // a decoy must never look like the character the checker is waiting for
  logic [7:0] w_exp_gap;
  logic [7:0] w_gcap, w_glow, w_tcap, w_tlow;

  assign w_exp_gap = msg_char(3'(r_idx + 3'd1));
  assign w_gcap    = (w_dec_cap == w_exp_gap) ? FILL : w_dec_cap;
  assign w_glow    = (w_dec_low == w_exp_gap) ? FILL : w_dec_low;
  assign w_tcap    = (w_dec_cap == 8'h49)     ? FILL : w_dec_cap;
  assign w_tlow    = (w_dec_low == 8'h49)     ? FILL : w_dec_low;

  // message sequencer; every output is loaded with its value for the coming cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= 3'd0;
      r_cap     <= FILL;
      r_low     <= FILL;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_msg_cnt <= 16'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cap <= FILL;
          r_low <= FILL;
          if (start) begin
            r_state <= S_EMIT;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_busy  <= 1'b1;
            r_cap   <= msg_char(3'd0);
          end
        end
        S_EMIT: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt <= '0;
            if (r_idx != 3'd7) begin
              r_state <= S_GAP;
              r_cap   <= w_gcap;
              r_low   <= w_glow;
            end else begin
              r_state <= S_TAIL;
              r_cap   <= w_tcap;
              r_low   <= w_tlow;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_idx   <= 3'(r_idx + 3'd1);
            r_state <= S_EMIT;
            r_cap   <= msg_is_cap(3'(r_idx + 3'd1)) ? w_exp_gap : FILL;
            r_low   <= msg_is_cap(3'(r_idx + 3'd1)) ? FILL : w_exp_gap;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            r_cap <= w_gcap;
            r_low <= w_glow;
          end
        end
        default: begin // S_TAIL
          if (r_cnt == TAIL_LAST) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
            if (repeat_en) begin
              r_state <= S_EMIT;
              r_cap   <= msg_char(3'd0);
              r_low   <= FILL;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_cap   <= FILL;
              r_low   <= FILL;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
            r_cap <= w_tcap;
            r_low <= w_tlow;
            if (r_cnt == TAIL_DONE) begin
              r_done    <= 1'b1;
              r_msg_cnt <= r_msg_cnt + 16'd1;
            end
          end
        end
      endcase
    end
  end

  assign cap_flow = r_cap;
  assign low_flow = r_low;
  assign char_idx = {1'b0, r_idx};
  assign busy     = r_busy;
  assign done     = r_done;
  assign msg_cnt  = r_msg_cnt;

endmodule

// File: tb/tb_iloveyou_flow_gen.sv
// tb/tb_iloveyou_flow_gen.sv - randomized bench for iloveyou_flow_gen against a schedule model
module tb_iloveyou_flow_gen;

  localparam int         HOLD    = 1;
  localparam int         GAP     = 2;
  localparam int         MSG_GAP = 4;
  localparam logic [7:0] FILL    = 8'h5F;
  localparam int         P       = HOLD + GAP;
  localparam int         BODY    = 8 * HOLD + 7 * GAP;
  localparam int         L       = BODY + MSG_GAP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        repeat_en = 1'b0;
  logic [7:0]  cap_flow, low_flow;
  logic [3:0]  char_idx;
  logic        busy, done;
  logic [15:0] msg_cnt;

  int n_vec = 0;
  int n_err = 0;

  byte unsigned msg_b [8] = '{8'h49, 8'h4C, 8'h6F, 8'h76, 8'h65, 8'h59, 8'h6F, 8'h75};

  // model: position within the current message schedule
  bit          m_active = 1'b0;
  int          m_t = 0;
  logic [15:0] m_cnt = 16'd0;

  iloveyou_flow_gen #(.HOLD(HOLD), .GAP(GAP), .MSG_GAP(MSG_GAP), .FILL(FILL)) dut (
    .clk(clk), .rst(rst), .start(start), .repeat_en(repeat_en),
    .cap_flow(cap_flow), .low_flow(low_flow), .char_idx(char_idx),
    .busy(busy), .done(done), .msg_cnt(msg_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  function automatic bit is_lower(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7A);
  endfunction

  function automatic bit exp_filler();
    return !m_active || (m_t >= BODY) || ((m_t % P) >= HOLD);
  endfunction

  function automatic logic [7:0] exp_lane(input bit cap);
    logic [7:0] c;
    if (exp_filler()) return FILL;
    c = msg_b[m_t / P];
    return (is_upper(c) == cap) ? c : FILL;
  endfunction

  function automatic logic [7:0] exp_next();
    if (m_t >= BODY) return 8'h49;
    return msg_b[m_t / P + 1];
  endfunction

  function automatic logic [3:0] exp_idx();
    if (!m_active) return 4'd0;
    if (m_t >= BODY) return 4'd7;
    return 4'(m_t / P);
  endfunction

  task automatic tick(input bit s, input bit r, input bit rep);
    start = s; rst = r; repeat_en = rep;
    @(posedge clk);
    if (r) begin
      m_active = 1'b0; m_t = 0; m_cnt = 16'd0;
    end else if (m_active) begin
      if (m_t == L - 1) begin
        if (rep) m_t = 0;
        else     m_active = 1'b0;
      end else begin
        m_t++;
        if (m_t == L - 1) m_cnt++;
      end
    end else if (s) begin
      m_active = 1'b1; m_t = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(0, 1, 0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    n_vec++;
    if (cap_flow !== FILL || low_flow !== FILL || busy !== 1'b0 || done !== 1'b0 ||
        msg_cnt !== 16'd0 || char_idx !== 4'd0) begin
      n_err++;
      $display("FAIL reset: cap=%h low=%h busy=%b done=%b cnt=%0d idx=%0d, want 5f 5f 0 0 0 0",
               cap_flow, low_flow, busy, done, msg_cnt, char_idx);
    end
  endtask

  task automatic test_single();
    logic [7:0] ec, el;
    tick(1, 0, 0);
    for (int t = 0; t < L + 2; t++) begin
      ec = 8'h00; el = 8'h00;
      case (t)
        0: ec = 8'h49; 3: ec = 8'h4C; 15: ec = 8'h59;
        6: el = 8'h6F; 9: el = 8'h76; 12: el = 8'h65; 18: el = 8'h6F; 21: el = 8'h75;
        default: ;
      endcase
`ifndef ILY_DECOY_EN
      if (ec == 8'h00) ec = FILL;
      if (el == 8'h00) el = FILL;
`endif
      if (ec != 8'h00) begin
        n_vec++;
        if (cap_flow !== ec) begin
          n_err++; $display("FAIL single_cap t=%0d: got %h want %h", t, cap_flow, ec);
        end
      end
      if (el != 8'h00) begin
        n_vec++;
        if (low_flow !== el) begin
          n_err++; $display("FAIL single_low t=%0d: got %h want %h", t, low_flow, el);
        end
      end
      n_vec++;
      if (done !== (t == 25) || busy !== (t <= 25)) begin
        n_err++;
        $display("FAIL single_ctl t=%0d: done=%b busy=%b want %b %b", t, done, busy, t == 25, t <= 25);
      end
      if (t == 25) begin
        n_vec++;
        if (msg_cnt !== 16'd1) begin
          n_err++; $display("FAIL single_cnt: got %0d want 1", msg_cnt);
        end
      end
      tick(0, 0, 0);
    end
  endtask

  task automatic test_repeat();
    int dones [$];
    bit busy_ok;
    logic [15:0] base;
    base = msg_cnt;
    busy_ok = 1'b1;
    tick(1, 0, 1);
    for (int t = 0; t < 3 * L + 6; t++) begin
      if (done === 1'b1) dones.push_back(t);
      if (t < 3 * L && busy !== 1'b1) busy_ok = 1'b0;
      tick(0, 0, (t < 2 * L));
    end
    n_vec++;
    if (dones.size() != 3) begin
      n_err++; $display("FAIL repeat_count: got %0d done pulses want 3", dones.size());
    end else begin
      n_vec++;
      if (dones[0] != 25 || dones[1] != 51 || dones[2] != 77) begin
        n_err++;
        $display("FAIL repeat_timing: got %0d %0d %0d want 25 51 77", dones[0], dones[1], dones[2]);
      end
    end
    n_vec++;
    if (!busy_ok || busy !== 1'b0) begin
      n_err++; $display("FAIL repeat_busy: continuous=%b final=%b want 1 0", busy_ok, busy);
    end
    n_vec++;
    if (msg_cnt !== 16'(base + 16'd3)) begin
      n_err++; $display("FAIL repeat_cnt: got %0d want %0d", msg_cnt, 16'(base + 16'd3));
    end
  endtask

  task automatic test_start_ignored();
    int dones [$];
    tick(1, 0, 0);
    for (int t = 0; t < 2 * L + 4; t++) begin
      if (done === 1'b1) dones.push_back(t);
      tick((t == 10) || (t == 25), 0, 0);
    end
    n_vec++;
    if (dones.size() != 1 || dones[0] != 25) begin
      n_err++;
      $display("FAIL start_ignored: got %0d dones first at %0d want 1 at 25",
               dones.size(), (dones.size() > 0) ? dones[0] : -1);
    end
  endtask

  task automatic test_mid_reset();
    int nd;
    tick(1, 0, 0);
    for (int t = 0; t < 13; t++) tick(0, 0, 0);
    tick(0, 1, 0);
    n_vec++;
    if (cap_flow !== FILL || low_flow !== FILL || busy !== 1'b0 || msg_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL mid_reset: cap=%h low=%h busy=%b cnt=%0d want 5f 5f 0 0",
               cap_flow, low_flow, busy, msg_cnt);
    end
    nd = 0;
    for (int t = 0; t < 2 * L; t++) begin
      tick(0, 0, 0);
      if (done === 1'b1) nd++;
    end
    n_vec++;
    if (nd != 0) begin
      n_err++; $display("FAIL mid_reset_done: got %0d done pulses want 0", nd);
    end
  endtask

  task automatic test_random();
    int ncyc;
    bit s, r, rep, lane_ok;
`ifdef ILY_DECOY_EN
    ncyc = 1000 * L + 40;
`else
    ncyc = 4000;
`endif
    for (int i = 0; i < ncyc; i++) begin
`ifdef ILY_DECOY_EN
      s = (i == 0); r = 1'b0; rep = 1'b1;
`else
      s = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 299) == 0);
      rep = $urandom_range(0, 1);
`endif
      tick(s, r, rep);
      n_vec++;
      if (busy !== m_active || done !== (m_active && m_t == L - 1) ||
          char_idx !== exp_idx() || msg_cnt !== m_cnt) begin
        n_err++;
        $display("FAIL random_ctl i=%0d: busy=%b done=%b idx=%0d cnt=%0d want %b %b %0d %0d",
                 i, busy, done, char_idx, msg_cnt, m_active, m_active && m_t == L - 1,
                 exp_idx(), m_cnt);
      end
      if (m_active && exp_filler()) begin
`ifdef ILY_DECOY_EN
        lane_ok = (cap_flow != exp_next()) && (low_flow != exp_next()) &&
                  (cap_flow == FILL || is_upper(cap_flow)) &&
                  (low_flow == FILL || is_lower(low_flow));
`else
        lane_ok = (cap_flow == FILL) && (low_flow == FILL);
`endif
      end else begin
        lane_ok = (cap_flow === exp_lane(1'b1)) && (low_flow === exp_lane(1'b0));
      end
      n_vec++;
      if (!lane_ok) begin
        n_err++;
        $display("FAIL random_lane i=%0d t=%0d: cap=%h low=%h want %h %h (next %h)",
                 i, m_t, cap_flow, low_flow, exp_lane(1'b1), exp_lane(1'b0), exp_next());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_start_ignored();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
